// File: rtl/inning_sequencer_if.sv
// Play-entry handshake and score-pulse exchange for inning_sequencer.
// master = play source / score-pulse unit side, slave = the sequencer.
interface inning_sequencer_if;
    logic       play_valid;
    logic       play_ready;
    logic [2:0] play_code;
    logic [6:0] basehit;
    logic [3:0] add_to_score;

    modport master (
        output play_valid, play_code, add_to_score,
        input  play_ready, basehit
    );

    modport slave (
        input  play_valid, play_code, add_to_score,
        output play_ready, basehit
    );
endinterface

// File: rtl/inning_sequencer.sv
// Baseball game-flow controller: bases, outs, half/inning, scores via score-pulse unit.
// Optional macro WALKOFF_EN ends the game as soon as the home side's lead is decisive.
module inning_sequencer #(
    parameter int INNINGS = 9,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    inning_sequencer_if.slave  play,
    output logic [SCORE_W-1:0] score_away,
    output logic [SCORE_W-1:0] score_home,
    output logic [3:0]         inning,
    output logic               half,
    output logic [1:0]         outs,
    output logic [2:0]         bases,
    output logic               game_over,
    output logic               score_err
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, UPDATE, DONE} state_t;

    localparam logic [3:0] LAST = 4'(INNINGS);

    state_t               state_q, state_d;
    logic [2:0]           code_q, code_d;
    logic [2:0]           runs_q, runs_d;
    logic [6:0]           basehit_q, basehit_d;
    logic [SCORE_W-1:0]   away_q, away_d, home_q, home_d;
    logic [3:0]           inning_q, inning_d;
    logic                 half_q, half_d;
    logic [1:0]           outs_q, outs_d;
    logic [2:0]           bases_q, bases_d;
    logic                 over_q, over_d;
    logic                 err_q, err_d;
    logic [2:0]           exp_runs, got_runs;
    logic                 got_ok, walk_top, walk_bot;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                   input logic [2:0] r);
        logic [SCORE_W+2:0] t;
        t = {3'b000, s} + {{SCORE_W{1'b0}}, r};
        return (|t[SCORE_W+2:SCORE_W]) ? '1 : t[SCORE_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            code_q    <= '0;
            runs_q    <= '0;
            basehit_q <= '0;
            away_q    <= '0;
            home_q    <= '0;
            inning_q  <= 4'd1;
            half_q    <= 1'b0;
            outs_q    <= '0;
            bases_q   <= '0;
            over_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            runs_q    <= runs_d;
            basehit_q <= basehit_d;
            away_q    <= away_d;
            home_q    <= home_d;
            inning_q  <= inning_d;
            half_q    <= half_d;
            outs_q    <= outs_d;
            bases_q   <= bases_d;
            over_q    <= over_d;
            err_q     <= err_d;
        end
    end

    // Runs the score-pulse unit should report for the latched hit and base state.
    always_comb begin
        exp_runs = {2'b00, bases_q[0]};
        case (code_q)
            3'd2:    exp_runs = {2'b00, bases_q[1]} + {2'b00, bases_q[0]};
            3'd3:    exp_runs = {2'b00, bases_q[2]} + {2'b00, bases_q[1]} + {2'b00, bases_q[0]};
            3'd4:    exp_runs = {2'b00, bases_q[2]} + {2'b00, bases_q[1]} + {2'b00, bases_q[0]} + 3'd1;
            default: exp_runs = {2'b00, bases_q[0]};
        endcase
    end

    always_comb begin
        got_ok   = 1'b1;
        got_runs = '0;
        case (play.add_to_score)
            4'b0000: got_runs = 3'd0;
            4'b0001: got_runs = 3'd1;
            4'b0010: got_runs = 3'd2;
            4'b0100: got_runs = 3'd3;
            4'b1000: got_runs = 3'd4;
            default: got_ok   = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        runs_d    = runs_q;
        basehit_d = '0;
        away_d    = away_q;
        home_d    = home_q;
        inning_d  = inning_q;
        half_d    = half_q;
        outs_d    = outs_q;
        bases_d   = bases_q;
        over_d    = over_q;
        err_d     = err_q;
        walk_top  = 1'b0;
        walk_bot  = 1'b0;

        case (state_q)
            IDLE: begin
                if (play.play_valid) begin
                    if (play.play_code == 3'd0) begin
                        code_d  = 3'd0;
                        state_d = UPDATE;
                    end else if (play.play_code <= 3'd4) begin
                        code_d    = play.play_code;
                        basehit_d = {bases_q, 4'b1000 >> (play.play_code - 3'd1)};
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                runs_d = got_runs;
                if (!got_ok || got_runs != exp_runs) err_d = 1'b1;
                state_d = UPDATE;
            end
            UPDATE: begin
                if (code_q == 3'd0) begin
                    if (outs_q == 2'd2) begin
                        outs_d  = '0;
                        bases_d = '0;
`ifdef WALKOFF_EN
                        walk_top = !half_q && inning_q == LAST && home_q > away_q;
`endif
                        if (walk_top) begin
                            over_d = 1'b1;
                        end else if (!half_q) begin
                            half_d = 1'b1;
                        end else if (inning_q == LAST) begin
                            over_d = 1'b1;
                        end else begin
                            half_d   = 1'b0;
                            inning_d = inning_q + 4'd1;
                        end
                    end else begin
                        outs_d = outs_q + 2'd1;
                    end
                end else begin
                    if (half_q) home_d = sat_add(home_q, runs_q);
                    else        away_d = sat_add(away_q, runs_q);
                    case (code_q)
                        3'd1:    bases_d = {1'b1, bases_q[2], bases_q[1]};
                        3'd2:    bases_d = {2'b01, bases_q[2]};
                        3'd3:    bases_d = 3'b001;
                        default: bases_d = 3'b000;
                    endcase
`ifdef WALKOFF_EN
                    walk_bot = half_q && inning_q == LAST && home_d > away_q;
`endif
                    if (walk_bot) over_d = 1'b1;
                end
                state_d = over_d ? DONE : IDLE;
            end
            default: state_d = DONE;
        endcase
    end

    assign play.play_ready = (state_q == IDLE);
    assign play.basehit    = basehit_q;
    assign score_away      = away_q;
    assign score_home      = home_q;
    assign inning          = inning_q;
    assign half            = half_q;
    assign outs            = outs_q;
    assign bases           = bases_q;
    assign game_over       = over_q;
    assign score_err       = err_q;
endmodule

// File: tb/tb_inning_sequencer.sv
// Directed bench: a default-size sequencer and a 1-inning, 2-bit-score sequencer.
module tb_inning_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       sel = 1'b0;
    logic       pv = 1'b0;
    logic [2:0] pcode = '0;
    logic [3:0] pulse = '0;
    int unsigned total = 0, bad = 0;

    inning_sequencer_if ifa ();
    inning_sequencer_if ifb ();

    assign ifa.play_valid   = pv & ~sel;
    assign ifb.play_valid   = pv & sel;
    assign ifa.play_code    = pcode;
    assign ifb.play_code    = pcode;
    assign ifa.add_to_score = pulse;
    assign ifb.add_to_score = pulse;

    logic [7:0] away_a, home_a;
    logic [1:0] away_b, home_b;
    logic [3:0] inn_a, inn_b;
    logic       half_a, half_b, go_a, go_b, err_a, err_b;
    logic [1:0] outs_a, outs_b;
    logic [2:0] bases_a, bases_b;

    inning_sequencer #(.INNINGS(9), .SCORE_W(8)) dut_a (
        .clk(clk), .reset(rst_a), .play(ifa.slave),
        .score_away(away_a), .score_home(home_a), .inning(inn_a), .half(half_a),
        .outs(outs_a), .bases(bases_a), .game_over(go_a), .score_err(err_a)
    );

    inning_sequencer #(.INNINGS(1), .SCORE_W(2)) dut_b (
        .clk(clk), .reset(rst_b), .play(ifb.slave),
        .score_away(away_b), .score_home(home_b), .inning(inn_b), .half(half_b),
        .outs(outs_b), .bases(bases_b), .game_over(go_b), .score_err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy();
        return sel ? ifb.play_ready : ifa.play_ready;
    endfunction

    function automatic logic [6:0] bh();
        return sel ? ifb.basehit : ifa.basehit;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_hit(input string tag, input logic [2:0] code, input logic [3:0] p,
                          input logic [6:0] exp_bh, input logic exp_rdy);
        pcode = code;
        pulse = p;
        pv    = 1'b1;
        tick();
        pv = 1'b0;
        check({tag, ".bh"}, bh(), exp_bh);
        check({tag, ".rdy1"}, rdy(), 0);
        tick();
        check({tag, ".bh0"}, bh(), 0);
        tick();
        check({tag, ".rdy3"}, rdy(), 0);
        tick();
        check({tag, ".rdy4"}, rdy(), exp_rdy);
    endtask

    task automatic do_out(input string tag, input logic exp_rdy);
        pcode = 3'd0;
        pv    = 1'b1;
        tick();
        pv = 1'b0;
        check({tag, ".rdy1"}, rdy(), 0);
        check({tag, ".bh"}, bh(), 0);
        tick();
        check({tag, ".rdy2"}, rdy(), exp_rdy);
    endtask

    initial begin
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        #0;
        check("a.rst.rdy", ifa.play_ready, 1);
        check("a.rst.bh", ifa.basehit, 0);
        check("a.rst.away", away_a, 0);
        check("a.rst.home", home_a, 0);
        check("a.rst.inn", inn_a, 1);
        check("a.rst.half", half_a, 0);
        check("a.rst.outs", outs_a, 0);
        check("a.rst.bases", bases_a, 0);
        check("a.rst.go", go_a, 0);
        check("a.rst.err", err_a, 0);

        // reserved code is consumed without leaving IDLE
        pcode = 3'd6;
        pv    = 1'b1;
        tick();
        pv = 1'b0;
        check("a.rsv.rdy", ifa.play_ready, 1);
        check("a.rsv.bh", ifa.basehit, 0);
        check("a.rsv.bases", bases_a, 0);

        do_hit("a.s1", 3'd1, 4'b0000, 7'b000_1000, 1'b1);
        check("a.s1.bases", bases_a, 3'b100);
        check("a.s1.away", away_a, 0);
        do_hit("a.s2", 3'd1, 4'b0000, 7'b100_1000, 1'b1);
        check("a.s2.bases", bases_a, 3'b110);
        do_hit("a.s3", 3'd1, 4'b0000, 7'b110_1000, 1'b1);
        check("a.s3.bases", bases_a, 3'b111);
        do_hit("a.hr", 3'd4, 4'b1000, 7'b111_0001, 1'b1);
        check("a.hr.away", away_a, 4);
        check("a.hr.bases", bases_a, 0);
        check("a.hr.err", err_a, 0);
        do_hit("a.s4", 3'd1, 4'b0000, 7'b000_1000, 1'b1);
        do_hit("a.d1", 3'd2, 4'b0000, 7'b100_0100, 1'b1);
        check("a.d1.bases", bases_a, 3'b011);
        check("a.d1.err", err_a, 0);
        do_hit("a.d2", 3'd2, 4'b0001, 7'b011_0100, 1'b1);
        check("a.d2.away", away_a, 5);
        check("a.d2.err", err_a, 1);
        check("a.d2.bases", bases_a, 3'b010);
        do_hit("a.s5", 3'd1, 4'b0000, 7'b010_1000, 1'b1);
        check("a.s5.bases", bases_a, 3'b101);
        check("a.s5.err", err_a, 1);

        do_out("a.o1", 1'b1);
        check("a.o1.outs", outs_a, 1);
        check("a.o1.bases", bases_a, 3'b101);
        do_out("a.o2", 1'b1);
        check("a.o2.outs", outs_a, 2);
        do_out("a.o3", 1'b1);
        check("a.o3.half", half_a, 1);
        check("a.o3.outs", outs_a, 0);
        check("a.o3.bases", bases_a, 0);
        check("a.o3.inn", inn_a, 1);
        do_out("a.o4", 1'b1);
        do_out("a.o5", 1'b1);
        do_out("a.o6", 1'b1);
        check("a.o6.inn", inn_a, 2);
        check("a.o6.half", half_a, 0);
        check("a.o6.away", away_a, 5);
        check("a.o6.home", home_a, 0);

        // single-inning game on the small instance
        sel = 1'b1;
        check("b.rst.rdy", ifb.play_ready, 1);
        do_out("b.o1", 1'b1);
        do_out("b.o2", 1'b1);
        do_out("b.o3", 1'b1);
        check("b.top.half", half_b, 1);
        check("b.top.go", go_b, 0);
`ifdef WALKOFF_EN
        do_hit("b.hr", 3'd4, 4'b0001, 7'b000_0001, 1'b0);
        check("b.walk.home", home_b, 1);
        check("b.walk.go", go_b, 1);
`else
        do_hit("b.hr", 3'd4, 4'b0001, 7'b000_0001, 1'b1);
        check("b.hr.home", home_b, 1);
        check("b.hr.go", go_b, 0);
        do_out("b.o4", 1'b1);
        do_out("b.o5", 1'b1);
        do_out("b.o6", 1'b0);
        check("b.end.go", go_b, 1);
        check("b.end.inn", inn_b, 1);
        check("b.end.half", half_b, 1);
`endif
        pcode = 3'd1;
        pv    = 1'b1;
        tick();
        tick();
        tick();
        pv = 1'b0;
        check("b.done.rdy", ifb.play_ready, 0);
        check("b.done.bh", ifb.basehit, 0);
        check("b.done.bases", bases_b, 0);
        check("b.done.home", home_b, 1);
        check("b.done.go", go_b, 1);

        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check("b.rst2.go", go_b, 0);
        check("b.rst2.rdy", ifb.play_ready, 1);
        do_hit("b.sat1", 3'd4, 4'b0001, 7'b000_0001, 1'b1);
        do_hit("b.sat2", 3'd4, 4'b0001, 7'b000_0001, 1'b1);
        do_hit("b.sat3", 3'd4, 4'b0001, 7'b000_0001, 1'b1);
        check("b.sat3.away", away_b, 3);
        do_hit("b.sat4", 3'd4, 4'b0001, 7'b000_0001, 1'b1);
        check("b.sat4.away", away_b, 3);
        check("b.sat4.err", err_b, 0);

        // reset applied while the HR is in WAIT cancels it
        pcode = 3'd4;
        pulse = 4'b0001;
        pv    = 1'b1;
        tick();
        pv = 1'b0;
        check("b.inflt.bh", ifb.basehit, 7'b000_0001);
        tick();
        rst_b = 1'b1;
        tick();
        check("b.wrst.away", away_b, 0);
        check("b.wrst.bh", ifb.basehit, 0);
        check("b.wrst.rdy", ifb.play_ready, 1);
        check("b.wrst.inn", inn_b, 1);
        check("b.wrst.half", half_b, 0);
        check("b.wrst.outs", outs_b, 0);
        check("b.wrst.bases", bases_b, 0);
        check("b.wrst.go", go_b, 0);
        check("b.wrst.err", err_b, 0);
        rst_b = 1'b0;
        tick();
        tick();
        check("b.post.away", away_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
